// File: rtl/pipe_pkg.sv
// +-----------------------------------------------------------------+
// | pipe_pkg: shared types for the pipeline skid stage              |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam skid_state_t STATE_RESET = EMPTY;

endpackage

`default_nettype wire

// File: rtl/skid_slot.sv
// +-----------------------------------------------------------------+
// | skid_slot: N-bit enabled data register, clears on reset=0       |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

module skid_slot #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_d;
  logic [N-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clock) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// +-----------------------------------------------------------------+
// | pipe_skid_stage: valid/ready pipeline register with 1-entry     |
// | skid buffer; PIPE_SKID_STATS_EN adds a saturating stall counter |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_SKID_STATS_EN
  output logic [CNT_W-1:0] stall_count,
`endif
  output logic [N-1:0]     out_data
);

  skid_state_t  state_d;
  skid_state_t  state_q;
  logic         main_en;
  logic         skid_en;
  logic [N-1:0] main_in;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;

  // Handshake outputs decode only the state register, so in_ready never
  // sees out_ready combinationally.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_in = in_data;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_en = 1'b1;
          main_in = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = STATE_RESET;
    endcase
    // Squash drops this cycle's transfers; data registers keep stale contents.
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= STATE_RESET;
    else        state_q <= state_d;
  end

  skid_slot #(.N(N)) u_main (
    .clock (clock),
    .reset (reset),
    .en    (main_en),
    .d     (main_in),
    .q     (main_q)
  );

  skid_slot #(.N(N)) u_skid (
    .clock (clock),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] stall_count_q;

  always_comb begin
    stall_count_d = stall_count_q;
    if (out_valid && !out_ready && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// +-----------------------------------------------------------------+
// | tb_pipe_skid_stage: table-driven directed bench, N=8            |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_pipe_skid_stage;

  localparam int N     = 8;
  localparam int CNT_W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_count;
`endif

  always #5 clk = ~clk;

  pipe_skid_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clock       (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef PIPE_SKID_STATS_EN
    .stall_count (stall_count),
`endif
    .out_data    (out_data)
  );

  typedef struct {
    logic         rst_n;
    logic         fl;
    logic         iv;
    logic [N-1:0] d;
    logic         ordy;
    logic         e_ov;
    logic         e_ir;
    logic [N-1:0] e_od;
    logic         chk_d;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic rst_n, input logic fl, input logic iv,
                     input logic [N-1:0] d, input logic ordy, input logic e_ov,
                     input logic e_ir, input logic [N-1:0] e_od, input logic chk_d);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od; v.chk_d = chk_d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic fl, input logic iv,
                       input logic [N-1:0] d, input logic ordy);
    reset = rst_n; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst fl iv data ordy | ov ir data chk
    // reset held with traffic present, then first accept
    add(0, 0, 1, 8'hAA, 0,   0, 1, 8'h00, 1);
    add(0, 0, 1, 8'hAA, 0,   0, 1, 8'h00, 1);
    add(1, 0, 1, 8'hAA, 0,   1, 1, 8'hAA, 1);
    add(1, 0, 0, 8'h00, 1,   0, 1, 8'h00, 0);
    // streaming, no bubbles
    add(1, 0, 1, 8'h01, 1,   1, 1, 8'h01, 1);
    add(1, 0, 1, 8'h02, 1,   1, 1, 8'h02, 1);
    add(1, 0, 1, 8'h03, 1,   1, 1, 8'h03, 1);
    add(1, 0, 1, 8'h04, 1,   1, 1, 8'h04, 1);
    add(1, 0, 1, 8'h05, 1,   1, 1, 8'h05, 1);
    add(1, 0, 0, 8'h00, 1,   0, 1, 8'h00, 0);
    // backpressure into FULL, blocked offer, then drain in order
    add(1, 0, 1, 8'h10, 0,   1, 1, 8'h10, 1);
    add(1, 0, 1, 8'h11, 0,   1, 0, 8'h10, 1);
    add(1, 0, 1, 8'h12, 0,   1, 0, 8'h10, 1);
    add(1, 0, 1, 8'h12, 0,   1, 0, 8'h10, 1);
    add(1, 0, 1, 8'h12, 0,   1, 0, 8'h10, 1);
    add(1, 0, 1, 8'h12, 1,   1, 1, 8'h11, 1);
    add(1, 0, 1, 8'h12, 1,   1, 1, 8'h12, 1);
    add(1, 0, 0, 8'h00, 1,   0, 1, 8'h00, 0);
    // flush while FULL discards held items and the concurrent offer
    add(1, 0, 1, 8'h10, 0,   1, 1, 8'h10, 1);
    add(1, 0, 1, 8'h11, 0,   1, 0, 8'h10, 1);
    add(1, 1, 1, 8'h55, 0,   0, 1, 8'h00, 0);
    add(1, 0, 0, 8'h00, 1,   0, 1, 8'h00, 0);
    add(1, 0, 1, 8'h66, 0,   1, 1, 8'h66, 1);
    add(1, 0, 0, 8'h00, 0,   1, 1, 8'h66, 1);
    // reset beats flush mid-stall
    add(0, 1, 1, 8'h77, 0,   0, 1, 8'h00, 1);
    add(1, 0, 0, 8'h00, 0,   0, 1, 8'h00, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      check("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      check("in_ready", i, {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      if (vecs[i].chk_d) check("out_data", i, {24'd0, out_data}, {24'd0, vecs[i].e_od});
    end

    // FULL drain with simultaneous refill keeps strict order: 20,21 then 22
    drive(1, 0, 1, 8'h20, 0);
    drive(1, 0, 1, 8'h21, 0);
    drive(1, 0, 1, 8'h22, 1);
    check("seq_full_drain", 0, {24'd0, out_data}, 32'h21);
    check("seq_full_ready", 0, {31'd0, in_ready}, 32'd1);
    drive(1, 0, 1, 8'h22, 1);
    check("seq_refill", 0, {24'd0, out_data}, 32'h22);
    drive(1, 0, 0, 8'h00, 1);
    check("seq_empty", 0, {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_STATS_EN
    begin
      logic [CNT_W-1:0] exp_sc[6];
      exp_sc[0] = 2'd1; exp_sc[1] = 2'd2; exp_sc[2] = 2'd3;
      exp_sc[3] = 2'd3; exp_sc[4] = 2'd3; exp_sc[5] = 2'd3;
      drive(0, 0, 0, 8'h00, 0);
      check("stall_reset", 0, {30'd0, stall_count}, 32'd0);
      drive(1, 0, 1, 8'hA5, 0);
      check("stall_load", 0, {30'd0, stall_count}, 32'd0);
      for (int k = 0; k < 6; k++) begin
        drive(1, 0, 0, 8'h00, 0);
        check("stall_count", k, {30'd0, stall_count}, {30'd0, exp_sc[k]});
      end
      drive(1, 1, 0, 8'h00, 0);
      check("stall_flush", 0, {30'd0, stall_count}, 32'd3);
      check("stall_flush_ov", 0, {31'd0, out_valid}, 32'd0);
      drive(1, 0, 1, 8'hB6, 0);
      drive(0, 1, 0, 8'h00, 0);
      check("stall_rst_mid", 0, {30'd0, stall_count}, 32'd0);
      check("stall_rst_data", 0, {24'd0, out_data}, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parameterized N-bit pipeline stage register with valid/ready handshake and a one-entry skid buffer.
It sits between two datapath stages of the vector CPU pipeline, for example decode to execute, or execute to writeback.
It decouples upstream stall propagation, because in_ready is driven only from flops.
It sustains 1 transfer/cycle and supports a synchronous flush for branch/exception squash.

Parameters:
N, 32, data width in bits (N >= 1)
CNT_W, 16, width of stall counter (used only with PIPE_SKID_STATS_EN)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
flush  input  1  synchronous squash of all held data
in_valid  input  1  upstream presents in_data
in_ready  output  1  stage can accept this cycle (flop-driven, no combinational path from out_ready)
in_data  input  N  upstream payload
out_valid  output  1  out_data holds a valid item
out_ready  input  1  downstream accepts this cycle
out_data  output  N  payload, driven directly from main register
stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0 (only with PIPE_SKID_STATS_EN)

Behaviour:
- Reset is synchronous and active-low. When reset=0 at a clock edge: state<=EMPTY, main<=0, skid<=0, stall_count<=0. Outputs after that edge: out_valid=0, in_ready=1, out_data=0.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - BUSY: main valid, out_valid=1, in_ready=1.
  - FULL: main and skid valid, out_valid=1, in_ready=0.
- EMPTY: in_fire -> main<=in_data, BUSY. Otherwise stay.
- BUSY:
  - in_fire & out_fire -> main<=in_data, stay BUSY.
  - in_fire only -> skid<=in_data, FULL.
  - out_fire only -> EMPTY.
  - Neither -> hold.
- FULL:
  - out_fire -> main<=skid, BUSY.
  - Otherwise hold. in_valid is ignored because in_ready=0.
- Latency: 1 cycle from in_fire to out_valid when EMPTY.
- Ordering is strictly FIFO. No item is lost or duplicated, and main is never overwritten while out_valid & !out_ready.
- Flush (when reset=1 and flush=1) -> EMPTY at the next edge. Any transfer in that cycle is discarded. Data registers keep stale contents, and out_data is don't-care while out_valid=0. Flush is legal mid-stall and in FULL.
- Priority: reset > flush > handshake.
- Output stability: out_data and out_valid must not change while out_valid=1 and out_ready=0, unless flush or reset is active.
- in_valid/in_data may change freely while in_ready=0.

Optional Feature:
PIPE_SKID_STATS_EN
- Defined:
  - stall_count increments by 1 each cycle with out_valid=1 & out_ready=0.
  - It saturates at 2^CNT_W-1 (no wrap).
  - It is cleared by reset only; flush does not clear it.
- Undefined: the stall_count port and counter logic are absent.

Decomposition:
- Package pipe_pkg holds:
  - typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t
  - localparam STATE_RESET = EMPTY
- Sub-module skid_slot #(N): enabled data register with ports clock, reset, en, d, q. q resets to 0 on reset=0. It is instantiated twice (main, skid).
- Control FSM stays in pipe_skid_stage.

Test Plan (N=8):
1. Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=8'hAA -> out_valid=0, in_ready=1, out_data=0. After reset=1 and one edge with in_valid=1 -> out_valid=1, out_data=8'hAA.
2. Streaming: out_ready=1 and in_valid=1 with data 1,2,3,4,5 on consecutive cycles -> out_data 1..5 one cycle later each, in_ready stays 1, no bubbles.
3. Backpressure:
   - Send 8'h10, 8'h11 with out_ready=0 -> state FULL, in_ready=0, out_data=8'h10 held.
   - Present 8'h12 for 3 cycles -> not accepted.
   - Raise out_ready -> outputs 8'h10, 8'h11, 8'h12 in order.
4. Flush in FULL: from the FULL state of scenario 3 (8'h10/8'h11 held), assert flush with in_valid=1, in_data=8'h55 -> next cycle out_valid=0, in_ready=1. 8'h55 never appears at the output.
5. Reset mid-operation: in BUSY with out_ready=0, drive reset=0 and flush=1 together -> EMPTY, out_data=0. With stats enabled, stall_count=0.
6. Stats (PIPE_SKID_STATS_EN, CNT_W=2): hold a valid item with out_ready=0 for 6 cycles -> stall_count reads 1,2,3,3,3,3. Flush -> stays 3.
